// File: rtl/gates_mux_bist_ctrl.sv
// Self-test sequencer for the NAND/NOR gate unit: passes functional a/b through when idle,
// otherwise sweeps all four input vectors and records pass/fail, error count and first failure.
module gates_mux_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ext_a,
    input  logic       ext_b,
    input  logic       nand_in,
    input  logic       nor_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic [2:0]  err_cnt_q, err_cnt_d;
    logic [1:0]  fail_vec_q, fail_vec_d;
    logic        mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            cnt_q      <= 4'd0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            fail_vec_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // Expected responses are derived from the vector being driven, not from a/b pins.
    assign mismatch = (nand_in != ~(vec_q[1] & vec_q[0])) ||
                      (nor_in  != ~(vec_q[1] | vec_q[0]));

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d      = 2'd0;
                    cnt_d      = 4'd0;
                    err_cnt_d  = 3'd0;
                    pass_d     = 1'b0;
                    fail_vec_d = 2'd0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + 3'd1;
                    if (err_cnt_q == 3'd0) begin
                        fail_vec_d = vec_q;
                    end
                end
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (err_cnt_d == 3'd0);
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == SETTLE) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign a        = busy ? vec_q[1] : ext_a;
    assign b        = busy ? vec_q[0] : ext_b;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gates_mux_bist_ctrl.sv
// Directed bench for gates_mux_bist_ctrl: table of self-test runs against a modelled gate unit
// with injectable faults, plus hand sequences for reset abort and idle pass-through.
module tb_gates_mux_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic       ext_a = 1'b0, ext_b = 1'b0;
    int         fault = 0;

    logic       a1, b1, busy1, done1, pass1, nand1, nor1;
    logic [2:0] err1;
    logic [1:0] fv1;
    logic       a3, b3, busy3, done3, pass3, nand3, nor3;
    logic [2:0] err3;
    logic [1:0] fv3;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Gate unit model: {nand, nor} with optional fault injection.
    function automatic logic [1:0] gate(input logic ga, input logic gb, input int f);
        logic nd, nr;
        nd = ~(ga & gb);
        nr = ~(ga | gb);
        case (f)
            1: nr = 1'b0;
            2: nd = 1'b1;
            3: nd = ~nd;
            5: nd = 1'b0;
            6: nr = 1'b1;
            default: ;
        endcase
        return {nd, nr};
    endfunction

    always_comb {nand1, nor1} = gate(a1, b1, fault);
    always_comb {nand3, nor3} = gate(a3, b3, fault);

    gates_mux_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ext_a(ext_a), .ext_b(ext_b),
        .nand_in(nand1), .nor_in(nor1), .a(a1), .b(b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    gates_mux_bist_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .ext_a(ext_a), .ext_b(ext_b),
        .nand_in(nand3), .nor_in(nor3), .a(a3), .b(b3), .busy(busy3), .done(done3),
        .pass(pass3), .err_cnt(err3), .fail_vec(fv3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int which;
        int settle;
        int fault;
        bit repulse;
        bit hold;
        bit exp_pass;
        int exp_err;
        int exp_fv;
    } run_t;

    run_t runs[11];

    task automatic sample(input int which, output logic sa, output logic sb, output logic sbusy,
                          output logic sdone, output logic spass, output int serr, output int sfv);
        if (which == 1) begin
            sa = a1; sb = b1; sbusy = busy1; sdone = done1; spass = pass1;
            serr = int'(err1); sfv = int'(fv1);
        end else begin
            sa = a3; sb = b3; sbusy = busy3; sdone = done3; spass = pass3;
            serr = int'(err3); sfv = int'(fv3);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 1) start1 = v;
        else            start3 = v;
    endtask

    task automatic do_run(input int idx, input run_t r);
        int   total;
        int   last;
        logic sa, sb, sbusy, sdone, spass;
        int   serr, sfv;
        bit   ok;
        total = 4 * (r.settle + 1);
        last  = r.hold ? total + 3 : total + 2;
        fault = r.fault;
        @(negedge clk);
        set_start(r.which, 1'b1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1 && !r.hold) set_start(r.which, 1'b0);
            if (r.repulse && (c == 3 || c == 5)) set_start(r.which, 1'b1);
            if (r.repulse && (c == 4 || c == 6)) set_start(r.which, 1'b0);
            {ext_a, ext_b} = 2'($urandom_range(0, 3));
            #1;
            sample(r.which, sa, sb, sbusy, sdone, spass, serr, sfv);
            chk($sformatf("run%0d busy c%0d", idx, c), int'(sbusy),
                ((c <= total) || (r.hold && c == total + 3)) ? 1 : 0);
            chk($sformatf("run%0d done c%0d", idx, c), int'(sdone), (c == total + 1) ? 1 : 0);
            if (c <= total)
                chk($sformatf("run%0d ab c%0d", idx, c), int'({sa, sb}), (c - 1) / (r.settle + 1));
            else if (c == total + 1)
                chk($sformatf("run%0d ab_passthru c%0d", idx, c), int'({sa, sb}), int'({ext_a, ext_b}));
            if (c == 1) begin
                chk($sformatf("run%0d cleared_pass", idx), int'(spass), 0);
                chk($sformatf("run%0d cleared_err", idx), serr, 0);
                chk($sformatf("run%0d cleared_fv", idx), sfv, 0);
            end
            if (c == total + 1) begin
                chk($sformatf("run%0d pass", idx), int'(spass), int'(r.exp_pass));
                chk($sformatf("run%0d err_cnt", idx), serr, r.exp_err);
                chk($sformatf("run%0d fail_vec", idx), sfv, r.exp_fv);
            end
        end
        if (r.hold) begin
            set_start(r.which, 1'b0);
            ok = 1'b0;
            for (int k = 0; k < 40 && !ok; k++) begin
                @(negedge clk);
                #1;
                sample(r.which, sa, sb, sbusy, sdone, spass, serr, sfv);
                if (sdone) ok = 1'b1;
            end
            chk($sformatf("run%0d relaunch_done_seen", idx), int'(ok), 1);
            @(negedge clk);
        end
        $display("run %0d: dut=%0d fault=%0d pass=%0d err_cnt=%0d fail_vec=%0d", idx, r.which,
                 r.fault, r.exp_pass, r.exp_err, r.exp_fv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic sa, sb, sbusy, sdone, spass;
        int   serr, sfv;
        bit   saw_done;

        //            which settle fault rep hold pass err fv
        runs[0]  = '{1, 1, 0, 0, 0, 1, 0, 0};
        runs[1]  = '{1, 1, 1, 0, 0, 0, 1, 0};
        runs[2]  = '{1, 1, 2, 0, 0, 0, 1, 3};
        runs[3]  = '{1, 1, 3, 0, 0, 0, 4, 0};
        runs[4]  = '{1, 1, 0, 0, 0, 1, 0, 0};
        runs[5]  = '{1, 1, 0, 1, 0, 1, 0, 0};
        runs[6]  = '{1, 1, 6, 0, 0, 0, 3, 1};
        runs[7]  = '{1, 1, 5, 0, 0, 0, 3, 0};
        runs[8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
        runs[9]  = '{3, 3, 0, 0, 0, 1, 0, 0};
        runs[10] = '{3, 3, 2, 0, 0, 0, 1, 3};

        // Reset state, with a/b following ext during reset.
        ext_a = 1'b1; ext_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", int'(busy1), 0);
        chk("reset done", int'(done1), 0);
        chk("reset pass", int'(pass1), 0);
        chk("reset err_cnt", int'(err1), 0);
        chk("reset fail_vec", int'(fv1), 0);
        chk("reset ab", int'({a1, b1}), 2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle pass-through with zero latency.
        for (int v = 0; v < 4; v++) begin
            {ext_a, ext_b} = 2'(v);
            #1;
            chk($sformatf("idle ab v%0d", v), int'({a1, b1}), v);
            chk($sformatf("idle ab3 v%0d", v), int'({a3, b3}), v);
            $display("idle ext=%0d ab=%0d", v, {a1, b1});
        end

        for (int i = 0; i < 11; i++) do_run(i, runs[i]);

        // Reset mid-run in cycle 4 with a faulty unit: aborts with results cleared, no done.
        fault = 3;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
        end
        #1;
        chk("abort pre_err_cnt", int'(err1), 1);
        chk("abort pre_busy", int'(busy1), 1);
        ext_a = 1'b0; ext_b = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy1), 0);
        chk("abort ab", int'({a1, b1}), 1);
        chk("abort err_cnt", int'(err1), 0);
        chk("abort fail_vec", int'(fv1), 0);
        chk("abort pass", int'(pass1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            sample(1, sa, sb, sbusy, sdone, spass, serr, sfv);
            if (sdone || sbusy) saw_done = 1'b1;
        end
        chk("abort no_done_no_busy", int'(saw_done), 0);
        $display("abort: reset in cycle 4, err_cnt=%0d busy=%0d", err1, busy1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
